// File: rtl/ker_mem_loader.sv
// Kernel BRAM loader: one DRAM burst read, each 512-bit beat unpacked into KER_WIDTH-bit
// words written one per cycle. Optional running XOR checksum under KER_LOAD_CHECKSUM_EN.
module ker_mem_loader #(
  parameter int KER_NUM        = 3,
  parameter int KER_WIDTH      = 75,
  parameter int KER_ADDR_BITS  = 11,
  parameter int DRAM_DATA_BITS = 512,
  parameter int DRAM_ADDR_BITS = 29
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_start,
  input  logic [$clog2(KER_NUM)-1:0]          i_ker_sel,
  input  logic [KER_ADDR_BITS:0]              i_ker_height,
  input  logic [DRAM_ADDR_BITS-1:0]           i_dram_base,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_err,
  output logic                                o_dram_rd_req,
  output logic [DRAM_ADDR_BITS-1:0]           o_dram_rd_addr,
  output logic [KER_ADDR_BITS:0]              o_dram_rd_len,
  input  logic                                i_dram_rd_gnt,
  input  logic [DRAM_DATA_BITS-1:0]           i_dram_rd_data,
  input  logic                                i_dram_rd_valid,
  output logic                                o_dram_rd_ready,
  output logic [KER_NUM-1:0]                  o_ker_wr_en,
  output logic [KER_ADDR_BITS-1:0]            o_ker_wr_addr,
  output logic [KER_WIDTH-1:0]                o_ker_wr_data,
  output logic [KER_WIDTH-1:0]                o_ker_checksum
);
  localparam int WPB = DRAM_DATA_BITS / KER_WIDTH;
  localparam int HW  = KER_ADDR_BITS + 1;
  localparam int IW  = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int CW  = $clog2(WPB + 1);
  localparam int BW  = WPB * KER_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_STREAM, S_FIN} state_t;

  state_t                       r_state;
  logic [$clog2(KER_NUM)-1:0]   r_sel;
  logic [HW-1:0]                r_height;
  logic [HW-1:0]                r_words_left;
  logic [BW-1:0]                r_buf;
  logic [IW-1:0]                r_idx;
  logic [CW-1:0]                r_cnt;
  logic [KER_ADDR_BITS-1:0]     r_addr;

  logic [KER_WIDTH-1:0]         w_word [WPB];
  logic                         w_wr;
  logic                         w_last_word;
  logic                         w_ready;
  logic                         w_acc;
  logic [CW-1:0]                w_load_n;
  logic [HW:0]                  w_len_full;
  logic [KER_NUM-1:0]           w_onehot;
  logic [KER_WIDTH-1:0]         w_wr_data;
  logic                         w_unused;

  for (genvar k = 0; k < WPB; k++) begin : g_word
    assign w_word[k] = r_buf[k*KER_WIDTH +: KER_WIDTH];
  end

  // r_cnt is the number of words still to be written from the buffered beat
  assign w_wr        = (r_state == S_STREAM) && (r_cnt != '0);
  assign w_last_word = w_wr && ({1'b0, r_addr} == r_height - HW'(1));
  assign w_ready     = (r_state == S_STREAM) && (r_words_left != '0) && (r_cnt <= CW'(1));
  assign w_acc       = w_ready && i_dram_rd_valid;
  assign w_load_n    = (r_words_left > HW'(WPB)) ? CW'(WPB) : CW'(r_words_left);
  assign w_len_full  = ({1'b0, i_ker_height} + (HW+1)'(WPB - 1)) / (HW+1)'(WPB);
  assign w_onehot    = KER_NUM'(1) << r_sel;
  assign w_wr_data   = w_word[r_idx];
  assign w_unused    = ^{i_dram_rd_data[DRAM_DATA_BITS-1:BW], w_len_full[HW]};

  assign o_dram_rd_ready = w_ready;
  assign o_ker_wr_en     = w_wr ? w_onehot  : '0;
  assign o_ker_wr_addr   = w_wr ? r_addr    : '0;
  assign o_ker_wr_data   = w_wr ? w_wr_data : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_sel          <= '0;
      r_height       <= '0;
      r_words_left   <= '0;
      r_buf          <= '0;
      r_idx          <= '0;
      r_cnt          <= '0;
      r_addr         <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
      o_dram_rd_req  <= 1'b0;
      o_dram_rd_addr <= '0;
      o_dram_rd_len  <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_sel        <= i_ker_sel;
            r_height     <= i_ker_height;
            r_words_left <= i_ker_height;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_idx        <= '0;
            o_busy       <= 1'b1;
            if (int'(i_ker_sel) >= KER_NUM) begin
              r_state <= S_FIN;
              o_done  <= 1'b1;
              o_err   <= 1'b1;
            end else if (i_ker_height == '0) begin
              r_state <= S_FIN;
              o_done  <= 1'b1;
            end else begin
              r_state        <= S_REQ;
              o_dram_rd_req  <= 1'b1;
              o_dram_rd_addr <= i_dram_base;
              o_dram_rd_len  <= w_len_full[HW-1:0];
            end
          end
        end
        S_REQ: begin
          if (i_dram_rd_gnt) begin
            r_state        <= S_STREAM;
            o_dram_rd_req  <= 1'b0;
            o_dram_rd_addr <= '0;
            o_dram_rd_len  <= '0;
          end
        end
        S_STREAM: begin
          if (w_wr) begin
            if (w_last_word) begin
              r_state <= S_FIN;
              o_done  <= 1'b1;
              r_addr  <= '0;
              r_cnt   <= '0;
            end else begin
              r_addr <= r_addr + KER_ADDR_BITS'(1);
              r_idx  <= r_idx + IW'(1);
              r_cnt  <= r_cnt - CW'(1);
            end
          end
          // a new beat lands only when the buffer is empty or draining its final word
          if (w_acc) begin
            r_buf        <= i_dram_rd_data[BW-1:0];
            r_idx        <= '0;
            r_cnt        <= w_load_n;
            r_words_left <= r_words_left - HW'(w_load_n);
          end
        end
        S_FIN: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef KER_LOAD_CHECKSUM_EN
  logic [KER_WIDTH-1:0] r_csum;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                            r_csum <= '0;
    else if (r_state == S_IDLE && i_start) r_csum <= '0;
    else if (w_wr)                         r_csum <= r_csum ^ w_wr_data;
  end

  assign o_ker_checksum = r_csum;
`else
  assign o_ker_checksum = '0;
`endif

endmodule

// File: tb/tb_ker_mem_loader.sv
// Directed bench for ker_mem_loader: DRAM responder pushes expected writes to a scoreboard,
// a negedge monitor pops and compares them; the main sequence checks handshakes and timing.
module tb_ker_mem_loader;
  localparam int KN = 3, KW = 75, KA = 11, DD = 512, DA = 29, WPB = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           i_start = 1'b0;
  logic [1:0]     i_ker_sel = '0;
  logic [KA:0]    i_ker_height = '0;
  logic [DA-1:0]  i_dram_base = '0;
  logic           i_gnt = 1'b0;
  logic [DD-1:0]  i_data = '0;
  logic           i_valid = 1'b0;
  logic           o_busy, o_done, o_err, o_req, o_ready;
  logic [DA-1:0]  o_raddr;
  logic [KA:0]    o_rlen;
  logic [KN-1:0]  o_wen;
  logic [KA-1:0]  o_waddr;
  logic [KW-1:0]  o_wdata, o_csum;

  ker_mem_loader dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_ker_sel(i_ker_sel),
    .i_ker_height(i_ker_height), .i_dram_base(i_dram_base),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_dram_rd_req(o_req), .o_dram_rd_addr(o_raddr), .o_dram_rd_len(o_rlen),
    .i_dram_rd_gnt(i_gnt), .i_dram_rd_data(i_data), .i_dram_rd_valid(i_valid),
    .o_dram_rd_ready(o_ready), .o_ker_wr_en(o_wen), .o_ker_wr_addr(o_waddr),
    .o_ker_wr_data(o_wdata), .o_ker_checksum(o_csum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [KN-1:0] en;
    logic [KA-1:0] addr;
    logic [KW-1:0] data;
  } wr_t;

  wr_t            sb[$];
  int             n_cmp = 0, n_err = 0;
  int             cyc = 0;
  int             exp_sel, exp_h, exp_base, n_beats;
  bit             gap_mode;
  int             beat_i, gap_left, req_cnt = 0, wr_cnt = 0, first_wr_cyc = 0, last_wr_cyc = 0;
  bit             streaming = 0, commit = 0, in_wr = 0;
  logic [DD-1:0]  cur_beat = '0;
  logic [KW-1:0]  xor_all = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DD-1:0] rand_beat();
    logic [DD-1:0] r;
    for (int i = 0; i < DD/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // DRAM responder plus write monitor, both on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      i_gnt = 0; i_valid = 0; streaming = 0; commit = 0; in_wr = 0;
      sb.delete();
    end else begin
      if (o_wen != '0) begin
        if (sb.size() == 0) chk("wr_unexpected", {o_wen, o_waddr}, 0);
        else begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_en", o_wen, e.en);
          chk("wr_addr", o_waddr, e.addr);
          chk("wr_data", o_wdata, e.data);
          xor_all = xor_all ^ e.data;
        end
        if (!in_wr) first_wr_cyc = cyc;
        in_wr = 1;
        wr_cnt++;
        last_wr_cyc = cyc;
      end
      if (o_done) in_wr = 0;

      if (i_gnt) begin
        i_gnt = 0; streaming = 1; cur_beat = rand_beat();
      end else if (o_req && !streaming) begin
        req_cnt++;
        chk("req_addr", o_raddr, exp_base);
        chk("req_len", o_rlen, n_beats);
        i_gnt = 1; beat_i = 0; commit = 0; gap_left = 0;
      end

      if (streaming) begin
        if (commit) begin
          commit = 0;
          beat_i++;
          if (gap_mode && beat_i % 4 == 0) gap_left = 3;
          cur_beat = rand_beat();
        end
        // gap cycles are counted only while the loader is actually ready
        if (gap_left > 0) begin
          i_valid = 0;
          if (o_ready) gap_left--;
        end else i_valid = (beat_i < n_beats);
        i_data = cur_beat;
        if (i_valid && o_ready) begin
          commit = 1;
          for (int k = 0; k < WPB; k++) begin
            if (beat_i*WPB + k < exp_h) begin
              wr_t w;
              w.en   = KN'(1) << exp_sel;
              w.addr = KA'(beat_i*WPB + k);
              w.data = cur_beat[k*KW +: KW];
              sb.push_back(w);
            end
          end
        end
        if (beat_i >= n_beats) streaming = 0;
      end
    end
  end

  task automatic start_load(int sel, int h, int base, bit gm);
    @(negedge clk);
    exp_sel = sel; exp_h = h; exp_base = base; n_beats = (h + WPB - 1) / WPB; gap_mode = gm;
    i_ker_sel = 2'(sel); i_ker_height = (KA+1)'(h); i_dram_base = DA'(base);
    i_start = 1;
    @(negedge clk);
    i_start = 0;
  endtask

  task automatic wait_done(string tag, int maxc);
    int n = 0;
    while (o_done !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, n < maxc, 1);
  endtask

  task automatic chk_csum(string tag, logic [KW-1:0] snap);
`ifdef KER_LOAD_CHECKSUM_EN
    chk(tag, o_csum, xor_all ^ snap);
`else
    chk(tag, o_csum, 0);
`endif
  endtask

  task automatic chk_outs_zero(string tag);
    chk({tag, "_ctl"}, {o_busy, o_done, o_err, o_req, o_raddr, o_rlen, o_ready, o_wen, o_waddr}, 0);
    chk({tag, "_data"}, {o_wdata, o_csum}, 0);
  endtask

  initial begin
    int r0, w0;
    logic [KW-1:0] snap;

    #2 chk_outs_zero("reset");
    repeat (2) @(negedge clk);
    rst = 0;

    // single beat, six words
    r0 = req_cnt; w0 = wr_cnt; snap = xor_all;
    start_load(0, 6, 'h100, 0);
    wait_done("h6", 100);
    chk("h6_reqs", req_cnt - r0, 1);
    chk("h6_writes", wr_cnt - w0, 6);
    chk("h6_done_lat", cyc - last_wr_cyc, 1);
    chk("h6_err", o_err, 0);
    chk("h6_sb_empty", sb.size(), 0);
    chk_csum("h6_csum", snap);
    @(negedge clk);
    chk("h6_idle", {o_busy, o_done}, 0);

    // full height, no bubbles
    r0 = req_cnt; w0 = wr_cnt;
    start_load(2, 1920, 'h2000, 0);
    wait_done("h1920", 2500);
    chk("h1920_reqs", req_cnt - r0, 1);
    chk("h1920_writes", wr_cnt - w0, 1920);
    chk("h1920_span", last_wr_cyc - first_wr_cyc, 1919);
    chk("h1920_sb_empty", sb.size(), 0);

    // partial last beat
    r0 = req_cnt; w0 = wr_cnt;
    start_load(1, 7, 'h55, 0);
    wait_done("h7", 100);
    chk("h7_reqs", req_cnt - r0, 1);
    chk("h7_writes", wr_cnt - w0, 7);
    chk("h7_sb_empty", sb.size(), 0);

    // valid gaps of three ready cycles after every 4th beat
    r0 = req_cnt; w0 = wr_cnt;
    start_load(0, 96, 'h400, 1);
    wait_done("gap", 400);
    chk("gap_writes", wr_cnt - w0, 96);
    chk("gap_span", last_wr_cyc - first_wr_cyc, 95 + 3*3);
    chk("gap_sb_empty", sb.size(), 0);

    // invalid select
    r0 = req_cnt;
    start_load(3, 6, 'h10, 0);
    chk("sel3_done_err_busy", {o_done, o_err, o_busy}, 3'b111);
    @(negedge clk);
    chk("sel3_after", {o_done, o_err, o_busy}, 0);
    chk("sel3_reqs", req_cnt - r0, 0);

    // zero height
    start_load(0, 0, 'h10, 0);
    chk("h0_done_err_busy", {o_done, o_err, o_busy}, 3'b101);
    chk_csum("h0_csum", xor_all);
    @(negedge clk);
    chk("h0_reqs", req_cnt - r0, 0);

    // start during STREAM is ignored
    r0 = req_cnt; w0 = wr_cnt;
    start_load(1, 96, 'h600, 0);
    repeat (20) @(negedge clk);
    i_ker_sel = 2'd0; i_ker_height = 12'd6; i_start = 1;
    @(negedge clk);
    i_start = 0;
    wait_done("ign", 300);
    chk("ign_reqs", req_cnt - r0, 1);
    chk("ign_writes", wr_cnt - w0, 96);
    chk("ign_sb_empty", sb.size(), 0);
    repeat (2) @(negedge clk);

    // reset mid-stream, then a normal load
    start_load(1, 96, 'h800, 0);
    repeat (30) @(negedge clk);
    rst = 1;
    #1 chk_outs_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 0;
    r0 = req_cnt; w0 = wr_cnt; snap = xor_all;
    start_load(0, 6, 'h40, 0);
    wait_done("post_rst", 100);
    chk("post_rst_reqs", req_cnt - r0, 1);
    chk("post_rst_writes", wr_cnt - w0, 6);
    chk_csum("post_rst_csum", snap);
    @(negedge clk);
    chk_csum("post_rst_csum_hold", snap);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ker_mem_loader.md
Name: ker_mem_loader

Overview:
- Fills one kernel BRAM from external DRAM before a layer starts.
- Issues a single burst read to the DRAM interface, accepts 512-bit beats, and unpacks each beat into KER_WIDTH-bit kernel words.
- Writes the words one per cycle into the selected kernel memory.
- Sits between the DRAM controller read channel and the KER_NUM kernel BRAM write ports. The conv engines use the other port of those BRAMs.

Parameters:
- KER_NUM, 3: number of kernel memories.
- KER_WIDTH, 75: kernel word width in bits.
- KER_ADDR_BITS, 11: kernel BRAM address width; covers height 1920.
- DRAM_DATA_BITS, 512: DRAM beat width.
- DRAM_ADDR_BITS, 29: DRAM beat address width.
- WPB, DRAM_DATA_BITS/KER_WIDTH (=6): words per beat. Derived; not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle load request; sampled only in IDLE.
- ker_sel  in  $clog2(KER_NUM)  target kernel memory.
- ker_height  in  KER_ADDR_BITS+1  number of words to load.
- dram_base  in  DRAM_ADDR_BITS  first beat address.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done when ker_sel >= KER_NUM.
- dram_rd_req  out  1  burst request; held until granted.
- dram_rd_addr  out  DRAM_ADDR_BITS  burst start address.
- dram_rd_len  out  KER_ADDR_BITS+1  burst length in beats.
- dram_rd_gnt  in  1  request accepted.
- dram_rd_data  in  DRAM_DATA_BITS  read beat.
- dram_rd_valid  in  1  beat valid.
- dram_rd_ready  out  1  beat accepted when valid&&ready.
- ker_wr_en  out  KER_NUM  one-hot BRAM write enable.
- ker_wr_addr  out  KER_ADDR_BITS  BRAM write address.
- ker_wr_data  out  KER_WIDTH  BRAM write data.
- ker_checksum  out  KER_WIDTH  see Optional Feature.

Behaviour:
- Reset (asynchronous): FSM to IDLE. All outputs 0, all counters and the beat buffer cleared. Asserting rst mid-burst abandons the load. Beats arriving after reset are not accepted because ready is 0; the DRAM side is flushed by its own reset.
- FSM states: IDLE, REQ, STREAM, FIN.
- IDLE, on start, latches ker_sel, ker_height and dram_base, then branches:
  - ker_sel >= KER_NUM: go to FIN with err.
  - ker_height == 0: go to FIN, no DRAM request.
  - Otherwise: go to REQ.
- Start while not IDLE is ignored.
- REQ:
  - dram_rd_req=1, dram_rd_addr=dram_base, dram_rd_len=ceil(ker_height/WPB).
  - On gnt, go to STREAM; req drops the next cycle.
- STREAM, beat buffer:
  - Holds one beat plus a word index 0..WPB-1.
  - Word k of a beat is data[k*KER_WIDTH +: KER_WIDTH], LSB first. Bits above WPB*KER_WIDTH are ignored.
- STREAM, ready:
  - dram_rd_ready=1 when beats remain, and either the buffer is empty or the buffer is emitting its last valid word this cycle.
  - This allows back-to-back beats without bubbles: one word per cycle sustained.
- STREAM, writes:
  - Beat accepted at cycle t: words written at t+1 .. t+WPB.
  - ker_wr_en has the selected bit set; ker_wr_addr increments from 0.
- Last beat: only ker_height mod WPB words are written (WPB if zero); the remaining words are discarded.
- After the write at address ker_height-1, go to FIN.
- FIN: done=1 (and err if flagged) for one cycle, busy=0 next cycle, return to IDLE.
- busy=1 in REQ, STREAM and FIN; also in the FIN cycle of a zero-length or erroneous start.
- Valid gaps stall the write stream; no write occurs while the buffer is empty.
- Address wrap: ker_wr_addr never exceeds ker_height-1. dram_rd_addr arithmetic is the DRAM controller's concern.

Optional Feature:
- Macro: KER_LOAD_CHECKSUM_EN.
- Defined:
  - A KER_WIDTH-bit register is cleared on accepted start.
  - It XORs every written ker_wr_data.
  - ker_checksum holds the final value from the done cycle until the next accepted start.
- Undefined: ker_checksum tied to 0; no register is inferred.

Test Plan:
- ker_sel=0, height=6, base=0x100:
  - Exactly one req with addr 0x100, len 1.
  - Six writes, addr 0..5 = words 0..5 of the beat.
  - done 1 cycle after the addr-5 write.
- ker_sel=2, height=1920, valid always high:
  - len 320.
  - 1920 consecutive writes with no bubble after the first.
  - ker_wr_en=3'b100 throughout.
- ker_sel=1, height=7:
  - len 2.
  - Addr 6 gets word 0 of beat 2; words 1..5 of beat 2 are never written.
- height=96, valid deasserted 3 cycles after every 4th beat:
  - Writes pause exactly during gaps.
  - Data order preserved; 96 writes total.
- Edge starts, no DRAM request in any case:
  - ker_sel=3: done+err one cycle after start.
  - height=0: done without err.
  - start pulsed during STREAM: ignored.
- rst asserted mid-STREAM of height 96:
  - All outputs 0 immediately.
  - A subsequent start with height 6 completes normally.
  - With KER_LOAD_CHECKSUM_EN: checksum equals the XOR of the six words.
